// File: rtl/gpio_out_pkg.sv
// gpio_out_pkg: shared types and default sizing for the GPIO output path.
package gpio_out_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int DEF_PULSE_LEN = 4;
    localparam int DEF_GAP_LEN   = 4;
    localparam int DEF_PEND_MAX  = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gpio_pulse_stretcher.sv
// gpio_pulse_stretcher: one pulse channel. Turns single-cycle events into
// pulses of PULSE_LEN high cycles separated by at least GAP_LEN low cycles,
// queueing up to PEND_MAX events that arrive while a pulse is in flight.
// The drop output exists only when GPIO_OUT_OVF_EN is defined.
module gpio_pulse_stretcher
    import gpio_out_pkg::*;
#(
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    parameter int GAP_LEN   = DEF_GAP_LEN,
    parameter int PEND_MAX  = DEF_PEND_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic evt,
`ifdef GPIO_OUT_OVF_EN
    output logic drop,
`endif
    output logic pulse
);

    localparam int CW = $clog2(max_int(PULSE_LEN, GAP_LEN) + 1);
    localparam int PW = $clog2(PEND_MAX + 1);

    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_LEN - 1);
    localparam logic [PW-1:0] PEND_SAT = PW'(PEND_MAX);

    state_e        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] pend, pend_n;
    logic          evt_q;
    logic          pend_full;
    logic          gap_end;

    // Events while disabled are ignored rather than queued.
    assign evt_q     = evt & ena;
    assign pend_full = (pend == PEND_SAT);
    assign gap_end   = (state == GAP) && (cnt == '0);

    // Output comes straight from the state register: no path from evt.
    assign pulse = (state == HIGH);

`ifdef GPIO_OUT_OVF_EN
    // An event is lost only if the queue is full and this cycle does not
    // start the next pulse (which would free a slot).
    assign drop = evt_q & pend_full & ~gap_end;
`endif

    // Next-state, counter and pending-queue logic.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        unique case (state)
            IDLE: begin
                if (evt_q) begin
                    state_n = HIGH;
                    cnt_n   = PULSE_LD;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    state_n = GAP;
                    cnt_n   = GAP_LD;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
                if (evt_q && !pend_full) pend_n = pend + 1'b1;
            end
            GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                    if (evt_q && !pend_full) pend_n = pend + 1'b1;
                end else if (pend != '0 || evt_q) begin
                    // Consume one queued event; a fresh event replaces it.
                    state_n = HIGH;
                    cnt_n   = PULSE_LD;
                    if (pend != '0 && !evt_q) pend_n = pend - 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                pend_n  = '0;
            end
        endcase
    end

    // State registers; reset beats enable, everything frozen when ena=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
        end else if (ena) begin
            state <= state_n;
            cnt   <= cnt_n;
            pend  <= pend_n;
        end
    end

endmodule

// File: rtl/gpio_out_wrapper.sv
// gpio_out_wrapper: GPIO output block with two stretched pulse channels
// (done, err) and a registered busy level. Define GPIO_OUT_OVF_EN to add the
// sticky overflow flag gpio_ovf and its clear input ovf_clr.
module gpio_out_wrapper
    import gpio_out_pkg::*;
#(
    parameter int PULSE_LEN = DEF_PULSE_LEN,
    parameter int GAP_LEN   = DEF_GAP_LEN,
    parameter int PEND_MAX  = DEF_PEND_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic done_evt,
    input  logic err_evt,
    input  logic busy,
`ifdef GPIO_OUT_OVF_EN
    input  logic ovf_clr,
    output logic gpio_ovf,
`endif
    output logic gpio_done,
    output logic gpio_err,
    output logic gpio_busy
);

`ifdef GPIO_OUT_OVF_EN
    logic drop_done;
    logic drop_err;
`endif

    gpio_pulse_stretcher #(
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .PEND_MAX  (PEND_MAX)
    ) u_done (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .evt   (done_evt),
`ifdef GPIO_OUT_OVF_EN
        .drop  (drop_done),
`endif
        .pulse (gpio_done)
    );

    gpio_pulse_stretcher #(
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .PEND_MAX  (PEND_MAX)
    ) u_err (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .evt   (err_evt),
`ifdef GPIO_OUT_OVF_EN
        .drop  (drop_err),
`endif
        .pulse (gpio_err)
    );

    // Busy level delayed by one enabled cycle.
    always_ff @(posedge clk) begin
        if (rst)      gpio_busy <= 1'b0;
        else if (ena) gpio_busy <= busy;
    end

`ifdef GPIO_OUT_OVF_EN
    // Sticky overflow: any drop sets it, set wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_ovf <= 1'b0;
        end else if (ena) begin
            if (drop_done || drop_err) gpio_ovf <= 1'b1;
            else if (ovf_clr)          gpio_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_out_wrapper.sv
// tb_gpio_out_wrapper: directed scenarios for gpio_out_wrapper with default
// parameters. Cycle c is the period starting at the c-th rising edge after
// reset release; outputs are sampled 1ns after that edge, and inputs set in
// cycle c are captured at the edge that starts cycle c+1.
module tb_gpio_out_wrapper;

    logic clk = 1'b0;
    logic rst, ena, done_evt, err_evt, busy;
    logic gpio_done, gpio_err, gpio_busy;
`ifdef GPIO_OUT_OVF_EN
    logic ovf_clr, gpio_ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    gpio_out_wrapper dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .done_evt  (done_evt),
        .err_evt   (err_evt),
        .busy      (busy),
`ifdef GPIO_OUT_OVF_EN
        .ovf_clr   (ovf_clr),
        .gpio_ovf  (gpio_ovf),
`endif
        .gpio_done (gpio_done),
        .gpio_err  (gpio_err),
        .gpio_busy (gpio_busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst      = 1'b1;
        ena      = 1'b1;
        done_evt = 1'b0;
        err_evt  = 1'b0;
        busy     = 1'b0;
`ifdef GPIO_OUT_OVF_EN
        ovf_clr  = 1'b0;
`endif
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if ({gpio_done, gpio_err, gpio_busy} !== 3'b000) begin
                n_err++;
                $display("FAIL reset c=%0d got %b want 000", c, {gpio_done, gpio_err, gpio_busy});
            end
`ifdef GPIO_OUT_OVF_EN
            n_cmp++;
            if (gpio_ovf !== 1'b0) begin
                n_err++;
                $display("FAIL reset.ovf c=%0d got %b want 0", c, gpio_ovf);
            end
`endif
            tick;
        end
    endtask

    task automatic test_single;
        logic exp_d;
        do_reset;
        for (int c = 0; c < 25; c++) begin
            exp_d = (c >= 11 && c <= 14);
            n_cmp++;
            if (gpio_done !== exp_d) begin
                n_err++;
                $display("FAIL single.done c=%0d got %b want %b", c, gpio_done, exp_d);
            end
            n_cmp++;
            if (gpio_err !== 1'b0) begin
                n_err++;
                $display("FAIL single.err c=%0d got %b want 0", c, gpio_err);
            end
            done_evt = (c == 10);
            tick;
        end
        done_evt = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic exp_d;
        do_reset;
        for (int c = 0; c < 45; c++) begin
            exp_d = (c >= 11 && c <= 14) || (c >= 19 && c <= 22) || (c >= 27 && c <= 30);
            n_cmp++;
            if (gpio_done !== exp_d) begin
                n_err++;
                $display("FAIL b2b.done c=%0d got %b want %b", c, gpio_done, exp_d);
            end
            done_evt = (c >= 10 && c <= 12);
            tick;
        end
        done_evt = 1'b0;
    endtask

    task automatic test_overflow;
        logic exp_d;
`ifdef GPIO_OUT_OVF_EN
        logic exp_o;
`endif
        do_reset;
        for (int c = 0; c < 55; c++) begin
            exp_d = (c >= 11 && c <= 14) || (c >= 19 && c <= 22) ||
                    (c >= 27 && c <= 30) || (c >= 35 && c <= 38);
            n_cmp++;
            if (gpio_done !== exp_d) begin
                n_err++;
                $display("FAIL ovf.done c=%0d got %b want %b", c, gpio_done, exp_d);
            end
`ifdef GPIO_OUT_OVF_EN
            exp_o = (c >= 15 && c <= 40);
            n_cmp++;
            if (gpio_ovf !== exp_o) begin
                n_err++;
                $display("FAIL ovf.flag c=%0d got %b want %b", c, gpio_ovf, exp_o);
            end
            ovf_clr = (c == 40);
`endif
            done_evt = (c >= 10 && c <= 15);
            tick;
        end
        done_evt = 1'b0;
`ifdef GPIO_OUT_OVF_EN
        ovf_clr = 1'b0;
`endif
    endtask

    task automatic test_simultaneous;
        logic exp_p;
        do_reset;
        for (int c = 0; c < 25; c++) begin
            exp_p = (c >= 11 && c <= 14);
            n_cmp++;
            if (gpio_done !== exp_p) begin
                n_err++;
                $display("FAIL simul.done c=%0d got %b want %b", c, gpio_done, exp_p);
            end
            n_cmp++;
            if (gpio_err !== exp_p) begin
                n_err++;
                $display("FAIL simul.err c=%0d got %b want %b", c, gpio_err, exp_p);
            end
            done_evt = (c == 10);
            err_evt  = (c == 10);
            tick;
        end
        done_evt = 1'b0;
        err_evt  = 1'b0;
    endtask

    task automatic test_busy;
        logic exp_b;
        do_reset;
        for (int c = 0; c < 12; c++) begin
            exp_b = (c >= 4 && c <= 6) || (c == 9);
            n_cmp++;
            if (gpio_busy !== exp_b) begin
                n_err++;
                $display("FAIL busy c=%0d got %b want %b", c, gpio_busy, exp_b);
            end
            busy = (c >= 3 && c <= 5) || (c == 8);
            tick;
        end
        busy = 1'b0;
    endtask

    task automatic test_reset_mid_pulse;
        logic exp_d, exp_b;
        do_reset;
        for (int c = 0; c < 40; c++) begin
            exp_d = (c >= 11 && c <= 12);
            exp_b = (c >= 6 && c <= 12);
            n_cmp++;
            if (gpio_done !== exp_d) begin
                n_err++;
                $display("FAIL rstmid.done c=%0d got %b want %b", c, gpio_done, exp_d);
            end
            n_cmp++;
            if (gpio_busy !== exp_b) begin
                n_err++;
                $display("FAIL rstmid.busy c=%0d got %b want %b", c, gpio_busy, exp_b);
            end
            done_evt = (c >= 10 && c <= 12);
            busy     = (c >= 5 && c <= 12);
            rst      = (c == 12);
            ena      = (c != 12);
            tick;
        end
        done_evt = 1'b0;
        busy     = 1'b0;
        rst      = 1'b0;
        ena      = 1'b1;
    endtask

    task automatic test_ena_freeze;
        logic exp_d;
        do_reset;
        for (int c = 0; c < 40; c++) begin
            exp_d = (c >= 11 && c <= 18);
            n_cmp++;
            if (gpio_done !== exp_d) begin
                n_err++;
                $display("FAIL ena.done c=%0d got %b want %b", c, gpio_done, exp_d);
            end
            n_cmp++;
            if (gpio_busy !== 1'b0) begin
                n_err++;
                $display("FAIL ena.busy c=%0d got %b want 0", c, gpio_busy);
            end
            ena      = !(c >= 12 && c <= 15);
            done_evt = (c == 10) || (c == 13);
            busy     = (c == 13);
            tick;
        end
        ena      = 1'b1;
        done_evt = 1'b0;
        busy     = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_overflow;
        test_simultaneous;
        test_busy;
        test_reset_mid_pulse;
        test_ena_freeze;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
